uart_tx_fifo: RTL and testbench
===============================

Name: uart_tx_fifo

Overview:
- Parametrised UART transmitter with an integrated transmit FIFO; successor to the fixed 8N1 transmit path of the uart block.
- Generalised in character width, parity mode, stop-bit count, baud divisor and buffer depth.
- Adds a valid/ready write interface and back-to-back frame streaming with no idle gap.
- Sits between the host write path and the serial pin; the receive path is out of scope.

Parameters:
DATA_W, 8, character width in bits; legal range 5..9
FIFO_DEPTH, 4, FIFO entries; power of two, >=2
CLKS_PER_BIT, 16, sys_clk cycles per serial bit; >=2
PARITY_MODE, 0, 0 = none, 1 = even, 2 = odd
STOP_BITS, 1, number of stop bits; 1 or 2

Ports:
sys_clk  in  1  single clock; all state on its rising edge
sys_rst  in  1  asynchronous, active-high reset
wr_valid  in  1  host presents a character
wr_data  in  DATA_W  character; bit 0 is transmitted first
wr_ready  out  1  FIFO can accept a character
uart_txd  out  1  serial line; idles high
tx_busy  out  1  high while a frame is on the line
tx_doneH  out  1  one-cycle pulse at the end of each frame
fifo_level  out  $clog2(FIFO_DEPTH+1)  number of entries held

Behaviour:
- Reset values: uart_txd=1, tx_busy=0, tx_doneH=0, fifo_level=0, wr_ready=1, FSM=IDLE. The FIFO is flushed.
- Reset asserted mid-frame forces uart_txd high asynchronously and abandons the frame. No tx_doneH pulse is issued.
- A write is accepted when wr_valid && wr_ready.
- wr_ready = (fifo_level < FIFO_DEPTH), decoded from registered state. There is no full-FIFO bypass: a write offered in the same cycle as a pop from a full FIFO is refused.
- fifo_level updates the cycle after a push or pop. A simultaneous push and pop leaves fifo_level unchanged.
- FIFO pointers wrap modulo FIFO_DEPTH. A full-bit or extra pointer bit distinguishes full from empty.
- FSM states are IDLE, START, DATA, PARITY, STOP.
  - IDLE, FIFO non-empty: pop the head into the shift register and go to START.
  - START: uart_txd=0 for CLKS_PER_BIT cycles.
  - DATA: DATA_W bits, LSB first, each held CLKS_PER_BIT cycles.
  - PARITY: entered only when PARITY_MODE!=0. Even mode sends the XOR of the character bits; odd mode sends its inverse. Held CLKS_PER_BIT cycles.
  - STOP: uart_txd=1 for STOP_BITS*CLKS_PER_BIT cycles.
- tx_doneH pulses in the last cycle of STOP. In that same cycle:
  - FIFO non-empty: pop and go directly to START, so frames run back to back with no idle cycle.
  - FIFO empty: go to IDLE.
- Frame length is exactly (1 + DATA_W + (PARITY_MODE!=0) + STOP_BITS) * CLKS_PER_BIT cycles.
- uart_txd and tx_busy are registered, glitch-free outputs. tx_busy=1 in every non-IDLE state.
- Latency for a write into an empty FIFO in IDLE: write at cycle n; pop at n+1; uart_txd low from n+2.
- Counters:
  - Baud counter: $clog2(CLKS_PER_BIT) bits; reloads at every bit boundary.
  - Bit counter: $clog2(DATA_W) bits. Separate stop counter.

Decomposition:
- Package uart_pkg holds:
  - state enum tx_state_t;
  - parity localparams PAR_NONE, PAR_EVEN, PAR_ODD;
  - function calc_parity(data, mode).
- One sub-module, uart_sync_fifo, parametrised by width and depth. It provides push/pop, full/empty flags and level. The FSM and shifter stay in uart_tx_fifo.

Test Plan:
- Config 8N1, CLKS_PER_BIT=4. Write 0xA5 -> uart_txd carries 0,1,0,1,0,0,1,0,1,1, each bit 4 cycles, 40 cycles total. tx_doneH pulses once at cycle 40 of the frame.
- Config 8E1. Write 0x07 -> parity bit 1, frame 44 cycles. Config 8O1: write 0x03 -> parity bit 1; write 0x07 -> parity bit 0.
- DEPTH=4. Write 6 characters on consecutive cycles from IDLE -> 5 accepted; wr_ready low on the 6th. The 6th is accepted the cycle after the first pop following frame 1. All 6 frames are back to back with no high gap beyond the stop bits.
- Config 7N2, CLKS_PER_BIT=3. Write 0x7F -> 10 bits, the last two high, 30 cycles. fifo_level goes 0->1->0.
- Assert sys_rst during DATA of frame 1 with 2 characters queued -> uart_txd=1 immediately, fifo_level=0, tx_busy=0, no tx_doneH. After release, the next write transmits normally.

Source files
------------

// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART transmit path:
//   tx_state_t   - transmitter FSM state encoding
//   PAR_*        - parity mode selectors
//   calc_parity  - parity bit for a character in a given mode
// -----------------------------------------------------------------------------
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } tx_state_t;

    localparam int PAR_NONE = 0;
    localparam int PAR_EVEN = 1;
    localparam int PAR_ODD  = 2;

    // Widest legal character; narrower characters are zero-extended,
    // which leaves the XOR unchanged.
    localparam int MAX_DATA_W = 9;

    // Even mode: XOR of the character bits. Odd mode: its inverse.
    function automatic logic calc_parity(input logic [MAX_DATA_W-1:0] data,
                                         input int                    mode);
        logic p;
        p = ^data;
        if (mode == PAR_ODD) begin
            p = ~p;
        end
        return p;
    endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// -----------------------------------------------------------------------------
// uart_sync_fifo
// Single-clock FIFO holding characters waiting for transmission.
//   clk, rst  - clock, asynchronous active-high reset (flushes the FIFO)
//   push      - write wdata (ignored when full)
//   pop       - drop the head entry (ignored when empty)
//   rdata     - head entry (valid while !empty)
//   full      - DEPTH entries held
//   empty     - no entries held
//   level     - number of entries held
// DEPTH must be a power of two; pointers carry one extra bit so that
// full and empty are distinguishable when the low bits match.
// -----------------------------------------------------------------------------
module uart_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [WIDTH-1:0]           wdata,
    input  logic                       pop,
    output logic [WIDTH-1:0]           rdata,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] level
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = $clog2(DEPTH + 1);

    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                   (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign level = LW'(wr_ptr - rd_ptr);
    assign rdata = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop && !empty) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    // Storage needs no reset: the pointers define which entries are live.
    always_ff @(posedge clk) begin
        if (push && !full) begin
            mem[wr_ptr[AW-1:0]] <= wdata;
        end
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// -----------------------------------------------------------------------------
// uart_tx_fifo
// Parametrised UART transmitter with an integrated transmit FIFO.
//   sys_clk    - clock, all state on the rising edge
//   sys_rst    - asynchronous active-high reset
//   wr_valid   - host presents a character
//   wr_data    - character, bit 0 transmitted first
//   wr_ready   - FIFO can accept a character (write = wr_valid && wr_ready)
//   uart_txd   - serial line, idles high (registered)
//   tx_busy    - high while a frame is on the line (registered)
//   tx_doneH   - one-cycle pulse in the last cycle of each frame
//   fifo_level - number of queued characters
// Handshake: a character is taken on a rising edge where wr_valid and
// wr_ready are both high; wr_ready depends only on registered state, so a
// full FIFO refuses writes even in a cycle where it is being popped.
// -----------------------------------------------------------------------------
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int DATA_W       = 8,
    parameter int FIFO_DEPTH   = 4,
    parameter int CLKS_PER_BIT = 16,
    parameter int PARITY_MODE  = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                            sys_clk,
    input  logic                            sys_rst,
    input  logic                            wr_valid,
    input  logic [DATA_W-1:0]               wr_data,
    output logic                            wr_ready,
    output logic                            uart_txd,
    output logic                            tx_busy,
    output logic                            tx_doneH,
    output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_level
);
    localparam int BAUD_W = $clog2(CLKS_PER_BIT);
    localparam int BIT_W  = $clog2(DATA_W);
    localparam logic [BAUD_W-1:0] LAST_BAUD = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0]  LAST_BIT  = BIT_W'(DATA_W - 1);
    localparam logic              LAST_STOP = 1'(STOP_BITS - 1);

    tx_state_t          state, state_n;
    logic [DATA_W-1:0]  shift, shift_n;
    logic               par_bit, par_n;
    logic [BAUD_W-1:0]  baud_cnt, baud_n;
    logic [BIT_W-1:0]   bit_cnt, bit_n;
    logic               stop_cnt, stop_n;
    logic               txd_q, txd_n;
    logic               busy_q, busy_n;
    logic               load;

    logic               fifo_full, fifo_empty, fifo_pop;
    logic [DATA_W-1:0]  fifo_rdata;

    logic bit_end;
    logic last_stop;

    uart_sync_fifo #(
        .WIDTH (DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (sys_clk),
        .rst   (sys_rst),
        .push  (wr_valid && wr_ready),
        .wdata (wr_data),
        .pop   (fifo_pop),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (fifo_level)
    );

    assign wr_ready  = !fifo_full;
    assign bit_end   = (baud_cnt == LAST_BAUD);
    assign last_stop = (stop_cnt == LAST_STOP);
    assign uart_txd  = txd_q;
    assign tx_busy   = busy_q;
    assign tx_doneH  = (state == STOP) && bit_end && last_stop;

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state    <= IDLE;
            shift    <= '0;
            par_bit  <= 1'b0;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            stop_cnt <= 1'b0;
            txd_q    <= 1'b1;
            busy_q   <= 1'b0;
        end else begin
            state    <= state_n;
            shift    <= shift_n;
            par_bit  <= par_n;
            baud_cnt <= baud_n;
            bit_cnt  <= bit_n;
            stop_cnt <= stop_n;
            txd_q    <= txd_n;
            busy_q   <= busy_n;
        end
    end

    // txd_n is the line level of the state being entered, so uart_txd
    // changes exactly at bit boundaries from a flop.
    always_comb begin
        state_n  = state;
        shift_n  = shift;
        par_n    = par_bit;
        bit_n    = bit_cnt;
        stop_n   = stop_cnt;
        txd_n    = txd_q;
        load     = 1'b0;
        fifo_pop = 1'b0;

        if (state == IDLE || bit_end) begin
            baud_n = '0;
        end else begin
            baud_n = baud_cnt + 1'b1;
        end

        unique case (state)
            IDLE: begin
                txd_n = 1'b1;
                if (!fifo_empty) begin
                    load = 1'b1;
                end
            end
            START: begin
                if (bit_end) begin
                    state_n = DATA;
                    bit_n   = '0;
                    txd_n   = shift[0];
                end
            end
            DATA: begin
                if (bit_end) begin
                    if (bit_cnt == LAST_BIT) begin
                        if (PARITY_MODE != PAR_NONE) begin
                            state_n = PARITY;
                            txd_n   = par_bit;
                        end else begin
                            state_n = STOP;
                            stop_n  = 1'b0;
                            txd_n   = 1'b1;
                        end
                    end else begin
                        shift_n = shift >> 1;
                        bit_n   = bit_cnt + 1'b1;
                        txd_n   = shift[1];
                    end
                end
            end
            PARITY: begin
                if (bit_end) begin
                    state_n = STOP;
                    stop_n  = 1'b0;
                    txd_n   = 1'b1;
                end
            end
            STOP: begin
                if (bit_end) begin
                    if (last_stop) begin
                        // Chain straight into the next frame when data waits.
                        if (!fifo_empty) begin
                            load = 1'b1;
                        end else begin
                            state_n = IDLE;
                            txd_n   = 1'b1;
                        end
                    end else begin
                        stop_n = 1'b1;
                    end
                end
            end
            default: begin
                state_n = IDLE;
                txd_n   = 1'b1;
            end
        endcase

        if (load) begin
            fifo_pop = 1'b1;
            state_n  = START;
            shift_n  = fifo_rdata;
            par_n    = calc_parity(MAX_DATA_W'(fifo_rdata), PARITY_MODE);
            txd_n    = 1'b0;
        end

        busy_n = (state_n != IDLE);
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
module tb_uart_tx_fifo;

    logic        sys_clk = 1'b0;
    logic        sys_rst = 1'b1;
    logic [3:0]  wr_valid = '0;
    logic [8:0]  wr_data = '0;
    logic [3:0]  wr_ready, uart_txd, tx_busy, tx_doneH;
    logic [2:0]  fifo_level [4];

    always #5 sys_clk = ~sys_clk;

    // 0: 8N1 cpb4, 1: 8E1 cpb4, 2: 8O1 cpb4, 3: 7N2 cpb3
    uart_tx_fifo #(.DATA_W(8), .FIFO_DEPTH(4), .CLKS_PER_BIT(4), .PARITY_MODE(0), .STOP_BITS(1)) u_8n1 (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .wr_valid(wr_valid[0]), .wr_data(wr_data[7:0]),
        .wr_ready(wr_ready[0]), .uart_txd(uart_txd[0]), .tx_busy(tx_busy[0]),
        .tx_doneH(tx_doneH[0]), .fifo_level(fifo_level[0]));
    uart_tx_fifo #(.DATA_W(8), .FIFO_DEPTH(4), .CLKS_PER_BIT(4), .PARITY_MODE(1), .STOP_BITS(1)) u_8e1 (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .wr_valid(wr_valid[1]), .wr_data(wr_data[7:0]),
        .wr_ready(wr_ready[1]), .uart_txd(uart_txd[1]), .tx_busy(tx_busy[1]),
        .tx_doneH(tx_doneH[1]), .fifo_level(fifo_level[1]));
    uart_tx_fifo #(.DATA_W(8), .FIFO_DEPTH(4), .CLKS_PER_BIT(4), .PARITY_MODE(2), .STOP_BITS(1)) u_8o1 (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .wr_valid(wr_valid[2]), .wr_data(wr_data[7:0]),
        .wr_ready(wr_ready[2]), .uart_txd(uart_txd[2]), .tx_busy(tx_busy[2]),
        .tx_doneH(tx_doneH[2]), .fifo_level(fifo_level[2]));
    uart_tx_fifo #(.DATA_W(7), .FIFO_DEPTH(4), .CLKS_PER_BIT(3), .PARITY_MODE(0), .STOP_BITS(2)) u_7n2 (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .wr_valid(wr_valid[3]), .wr_data(wr_data[6:0]),
        .wr_ready(wr_ready[3]), .uart_txd(uart_txd[3]), .tx_busy(tx_busy[3]),
        .tx_doneH(tx_doneH[3]), .fifo_level(fifo_level[3]));

    // Line monitor: one entry per clock cycle of the selected instance.
    logic       log_en = 1'b0;
    int         log_sel = 0;
    logic       line_q[$];
    logic       done_q[$];
    logic [2:0] lvl_q[$];

    always @(negedge sys_clk) begin
        if (log_en) begin
            line_q.push_back(uart_txd[log_sel]);
            done_q.push_back(tx_doneH[log_sel]);
            lvl_q.push_back(fifo_level[log_sel]);
        end
    end

    // Scoreboard: expected frames (bit 0 = first bit on the line).
    logic [15:0] exp_q[$];
    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic logic [15:0] make_frame(input logic [8:0] d, input int w,
                                               input int pm, input int stops);
        logic [15:0] v;
        logic        p;
        v = '1;
        p = 1'b0;
        v[0] = 1'b0;
        for (int i = 0; i < w; i++) begin
            v[1+i] = d[i];
            p = p ^ d[i];
        end
        if (pm != 0) begin
            v[1+w] = (pm == 1) ? p : ~p;
        end
        return v;
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge sys_clk);
        #1;
    endtask

    task automatic start_log(input int sel, output int base);
        log_sel = sel;
        base = line_q.size();
        log_en = 1'b1;
    endtask

    task automatic write_one(input int inst, input logic [8:0] d);
        logic acc;
        acc = 1'b0;
        wr_data = d;
        wr_valid[inst] = 1'b1;
        for (int k = 0; k < 200 && !acc; k++) begin
            acc = wr_ready[inst];
            tick(1);
        end
        wr_valid[inst] = 1'b0;
        chk("write_accept", 16'(acc), 16'd1);
    endtask

    // Decode nframes consecutive frames from the log, each nbits*cpb cycles,
    // starting at the first low sample after base.
    task automatic check_frames(input int base, input int nbits, input int cpb,
                                input int nframes, input string tag, output int first);
        logic [15:0] expv;
        logic        obs;
        int          st, idx, cnt, at;
        first = -1;
        for (int i = base; i < line_q.size(); i++) begin
            if (line_q[i] === 1'b0) begin
                first = i - base;
                break;
            end
        end
        chk({tag, "_start_found"}, 16'(first >= 0), 16'd1);
        if (first < 0) begin
            for (int f = 0; f < nframes; f++) void'(exp_q.pop_front());
            return;
        end
        for (int f = 0; f < nframes; f++) begin
            expv = exp_q.pop_front();
            st = base + first + f * nbits * cpb;
            for (int b = 0; b < nbits; b++) begin
                idx = st + b * cpb;
                obs = (idx < line_q.size()) ? line_q[idx] : 1'bx;
                for (int k = 0; k < cpb; k++) begin
                    if (idx + k >= line_q.size() || line_q[idx+k] !== obs) obs = 1'bx;
                end
                chk($sformatf("%s_f%0d_bit%0d", tag, f, b), 16'(obs), 16'(expv[b]));
            end
            cnt = 0;
            at = -1;
            for (int j = 0; j < nbits * cpb; j++) begin
                if (st + j < done_q.size() && done_q[st+j] === 1'b1) begin
                    cnt++;
                    at = j;
                end
            end
            chk($sformatf("%s_f%0d_done_count", tag, f), 16'(cnt), 16'd1);
            chk($sformatf("%s_f%0d_done_pos", tag, f), 16'(at), 16'(nbits * cpb - 1));
        end
        idx = base + first + nframes * nbits * cpb;
        chk({tag, "_idle_after"}, 16'((idx < line_q.size()) ? line_q[idx] : 1'bx), 16'd1);
    endtask

    int          base, first, cyc, cnt;
    logic [8:0]  d6 [6];

    initial begin
        // Reset state on all instances.
        tick(2);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("rst_txd_%0d", i), 16'(uart_txd[i]), 16'd1);
            chk($sformatf("rst_busy_%0d", i), 16'(tx_busy[i]), 16'd0);
            chk($sformatf("rst_done_%0d", i), 16'(tx_doneH[i]), 16'd0);
            chk($sformatf("rst_level_%0d", i), 16'(fifo_level[i]), 16'd0);
            chk($sformatf("rst_ready_%0d", i), 16'(wr_ready[i]), 16'd1);
        end
        sys_rst = 1'b0;
        tick(3);

        // 8N1, 0xA5: latency, bit pattern, level 0->1->0.
        start_log(0, base);
        exp_q.push_back(make_frame(9'h0A5, 8, 0, 1));
        write_one(0, 9'h0A5);
        tick(50);
        log_en = 1'b0;
        check_frames(base, 10, 4, 1, "8n1_a5", first);
        chk("8n1_latency", 16'(first), 16'd2);
        chk("8n1_level_n1", 16'(lvl_q[base+1]), 16'd1);
        chk("8n1_level_n2", 16'(lvl_q[base+2]), 16'd0);

        // 8E1, 0x07: parity 1, 44-cycle frame.
        start_log(1, base);
        exp_q.push_back(make_frame(9'h007, 8, 1, 1));
        write_one(1, 9'h007);
        tick(55);
        log_en = 1'b0;
        check_frames(base, 11, 4, 1, "8e1_07", first);

        // 8O1, 0x03 then 0x07 back to back: parity 1 then 0.
        start_log(2, base);
        exp_q.push_back(make_frame(9'h003, 8, 2, 1));
        exp_q.push_back(make_frame(9'h007, 8, 2, 1));
        write_one(2, 9'h003);
        write_one(2, 9'h007);
        tick(100);
        log_en = 1'b0;
        check_frames(base, 11, 4, 2, "8o1", first);

        // 8N1, six writes on consecutive cycles into a depth-4 FIFO.
        start_log(0, base);
        for (int i = 0; i < 6; i++) begin
            d6[i] = 9'($urandom_range(0, 255));
            exp_q.push_back(make_frame(d6[i], 8, 0, 1));
        end
        wr_valid[0] = 1'b1;
        for (int i = 0; i < 5; i++) begin
            wr_data = d6[i];
            chk($sformatf("stream_ready_%0d", i), 16'(wr_ready[0]), 16'd1);
            tick(1);
        end
        wr_data = d6[5];
        chk("stream_ready_full", 16'(wr_ready[0]), 16'd0);
        chk("stream_level_full", 16'(fifo_level[0]), 16'd4);
        cyc = 5;
        while (!wr_ready[0] && cyc < 200) begin
            tick(1);
            cyc++;
        end
        chk("stream_6th_accept_cycle", 16'(cyc), 16'd42);
        tick(1);
        wr_valid[0] = 1'b0;
        tick(6 * 40);
        log_en = 1'b0;
        check_frames(base, 10, 4, 6, "stream", first);
        chk("stream_latency", 16'(first), 16'd2);

        // 7N2 cpb3, 0x7F: 10 bits, 30 cycles, level 0->1->0.
        start_log(3, base);
        exp_q.push_back(make_frame(9'h07F, 7, 0, 2));
        write_one(3, 9'h07F);
        tick(40);
        log_en = 1'b0;
        check_frames(base, 10, 3, 1, "7n2_7f", first);
        chk("7n2_level_n0", 16'(lvl_q[base]), 16'd0);
        chk("7n2_level_n1", 16'(lvl_q[base+1]), 16'd1);
        chk("7n2_level_n2", 16'(lvl_q[base+2]), 16'd0);

        // Reset during DATA with two characters queued.
        start_log(0, base);
        write_one(0, 9'h011);
        write_one(0, 9'h022);
        write_one(0, 9'h033);
        tick(8);
        chk("midrst_busy_before", 16'(tx_busy[0]), 16'd1);
        chk("midrst_level_before", 16'(fifo_level[0]), 16'd2);
        sys_rst = 1'b1;
        #1;
        chk("midrst_txd", 16'(uart_txd[0]), 16'd1);
        chk("midrst_busy", 16'(tx_busy[0]), 16'd0);
        chk("midrst_level", 16'(fifo_level[0]), 16'd0);
        chk("midrst_done", 16'(tx_doneH[0]), 16'd0);
        tick(2);
        sys_rst = 1'b0;
        tick(2);
        log_en = 1'b0;
        cnt = 0;
        for (int i = base; i < done_q.size(); i++) if (done_q[i] === 1'b1) cnt++;
        chk("midrst_no_done", 16'(cnt), 16'd0);
        chk("midrst_idle_txd", 16'(uart_txd[0]), 16'd1);

        start_log(0, base);
        exp_q.push_back(make_frame(9'h03C, 8, 0, 1));
        write_one(0, 9'h03C);
        tick(50);
        log_en = 1'b0;
        check_frames(base, 10, 4, 1, "after_rst", first);

        chk("scoreboard_empty", 16'(exp_q.size()), 16'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
